m_rom_scroller: RTL
===================

Name: m_rom_scroller

Overview:
- Sequences the 16-entry 7-segment pattern ROM (4-bit address, 8-bit active-low segment data) onto an NDIG-digit multiplexed display.
- Generates ROM addresses, time-multiplexes digit anodes, and advances a scroll base pointer so the stored message marquees across the display.
- Sits between the pattern ROM instance and the board display pins.
- Controlled by start/stop pulses and a direction input.

Parameters:
- NDIG, 4, number of display digits (2..8).
- SCROLL_DIV, 50000000, clock cycles per scroll step (>=2).
- REFRESH_DIV, 50000, clock cycles per digit multiplex slot (>=2).

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: run/resume scrolling
- stop  in  1  one-cycle pulse: pause; a second stop returns to idle
- dir  in  1  0 = base+1 per step (text moves left), 1 = base-1
- rom_adr  out  4  address to pattern ROM (combinational from registered base/dig)
- rom_dat  in  8  pattern ROM data, combinational response to rom_adr
- seg  out  8  registered segment drive, active-low (bit0..6 = a..g, bit7 = dp)
- an  out  NDIG  registered digit enables, active-low, at most one low
- base  out  4  current scroll base address
- busy  out  1  high in RUN or PAUSE

Behaviour:
- Reset (async, n_reset=0): state=IDLE, base=0, dig=0, ref_cnt=0, scr_cnt=0, seg=8'hFF, an=all 1, busy=0, rom_adr=0. Takes effect immediately mid-operation.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE -start-> RUN: scr_cnt cleared on entry.
  - RUN -stop-> PAUSE.
  - PAUSE -start-> RUN: scr_cnt kept.
  - PAUSE -stop-> IDLE: base cleared to 0.
  - start and stop in the same cycle: stop wins (IDLE stays IDLE).
- ref_cnt:
  - Counts 0..REFRESH_DIV-1 in RUN and PAUSE; held at 0 in IDLE.
  - At the terminal count, dig advances dig+1, wrapping NDIG-1 -> 0.
- rom_adr = (base + dig) mod 16. 4-bit wrap, so adr 15 is followed by adr 0.
- Display registers, updated every cycle:
  - RUN/PAUSE: seg <= rom_dat, an <= ~(1 << dig).
  - IDLE: seg <= 8'hFF, an <= all 1.
  - Latency: seg/an reflect a dig/base change exactly 1 cycle later; seg and an always change together.
- dig 0 is the leftmost digit and shows base.
- scr_cnt:
  - Counts 0..SCROLL_DIV-1 only in RUN; frozen in PAUSE.
  - At the terminal count, base <= base+1 (dir=0) or base-1 (dir=1), mod 16.
  - dir is sampled on the step cycle only.
- A step and a refresh tick in the same cycle both apply; the new address is visible on seg 1 cycle later.
- busy is combinational from state.
- start in RUN and stop in IDLE are ignored.

Decomposition:
- Shared package m_disp_pkg:
  - state encoding (IDLE/RUN/PAUSE);
  - SEG_BLANK = 8'hFF;
  - ROM address width = 4.
- One sub-module m_tick_gen:
  - parameterised modulo-N counter with enable and synchronous clear;
  - emits a one-cycle tick at the terminal count;
  - instantiated twice, for refresh and for scroll.

Test Plan (bench instantiates the real pattern ROM; NDIG=4, SCROLL_DIV=8, REFRESH_DIV=2):
- Reset asserted mid-stream, then released -> seg=8'hFF, an=4'b1111, base=0, busy=0 while n_reset=0 and until start.
- start pulse, dir=0 -> busy=1 next cycle; first slot shows seg=8'hC2, an=4'b1110 (adr 0); 2 cycles later seg=8'hC0, an=4'b1101 (adr 1); full sweep shows C2,C0,C0,A1.
- RUN for 8 cycles, dir=0 -> base=1; digit0 shows 8'hC0, digit3 shows 8'h83 (adr 4). After 16 steps base wraps 15->0.
- dir=1 from base=0, one step -> base=15; digit0 seg=8'hFF (adr 15); digit1 seg=8'hC2 (adr 0).
- stop in RUN -> PAUSE: base unchanged over 40 cycles, an keeps cycling. Second stop -> IDLE: base=0, seg=8'hFF, an=4'b1111, busy=0.
- start and stop asserted the same cycle in IDLE -> remains IDLE. start in PAUSE -> resumes with scr_cnt preserved (next step after the remaining count).

Source files
------------

// File: rtl/m_disp_pkg.sv
// m_disp_pkg: shared definitions for the 7-segment ROM scroller.
//   state_e    - controller states (IDLE / RUN / PAUSE)
//   ADR_W      - pattern ROM address width
//   SEG_W      - segment bus width (a..g + dp)
//   SEG_BLANK  - active-low "all segments off" pattern
package m_disp_pkg;

  localparam int ADR_W = 4;
  localparam int SEG_W = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/m_tick_gen.sv
// m_tick_gen: modulo-N counter that emits a one-cycle tick at its terminal count.
//   clk, n_reset - clock, asynchronous active-low reset
//   en           - count enable
//   clr          - synchronous clear (dominates en)
//   tick         - high while enabled and the count sits at N-1
module m_tick_gen #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TERM = CW'(N - 1);

  logic [CW-1:0] cnt_r;

  // Modulo-N counter: clear first, then enabled count with wrap at N-1.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == TERM) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The tick ignores clr so a terminal count on a leaving cycle still lands.
  assign tick = en && (cnt_r == TERM);

endmodule

// File: rtl/m_rom_scroller.sv
// m_rom_scroller: marquees the 16-entry 7-segment pattern ROM across an
// NDIG-digit multiplexed, active-low display.
//   clk, n_reset - clock, asynchronous active-low reset
//   start        - pulse: run / resume scrolling
//   stop         - pulse: pause; a stop while paused returns to idle
//   dir          - 0: base+1 per step (text moves left), 1: base-1
//   rom_adr      - pattern ROM address, (base + dig) mod 16
//   rom_dat      - pattern ROM data, combinational in rom_adr
//   seg          - registered segment drive, active-low (bit0..6 = a..g, bit7 = dp)
//   an           - registered digit enables, active-low, one-hot-low
//   base         - current scroll base address (shown on leftmost digit 0)
//   busy         - high in RUN or PAUSE
module m_rom_scroller
  import m_disp_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int SCROLL_DIV  = 50000000,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  output logic [ADR_W-1:0] rom_adr,
  input  logic [SEG_W-1:0] rom_dat,
  output logic [SEG_W-1:0] seg,
  output logic [NDIG-1:0]  an,
  output logic [ADR_W-1:0] base,
  output logic             busy
);

  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DW-1:0]   DIG_LAST = DW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_ONE   = {{(NDIG-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_next_s;
  logic [ADR_W-1:0] base_r;
  logic [DW-1:0]    dig_r;
  logic [SEG_W-1:0] seg_r;
  logic [NDIG-1:0]  an_r;
  logic             ref_tick_s;
  logic             scr_tick_s;
  logic             ref_en_s;
  logic             ref_clr_s;
  logic             scr_en_s;
  logic             scr_clr_s;

  // Next-state logic; stop outranks start everywhere.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next_s = ST_PAUSE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_next_s = ST_IDLE;
        end else if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Refresh runs whenever the display is lit; it is parked at 0 on the way
  // into IDLE so the next run starts a fresh slot.
  assign ref_en_s  = (state_r != ST_IDLE);
  assign ref_clr_s = (state_next_s == ST_IDLE);

  // Scroll only advances in RUN; PAUSE freezes it, IDLE clears it so a fresh
  // start always waits a full step interval.
  assign scr_en_s  = (state_r == ST_RUN);
  assign scr_clr_s = (state_r == ST_IDLE);

  m_tick_gen #(.N(REFRESH_DIV)) u_ref_tick (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (ref_en_s),
    .clr     (ref_clr_s),
    .tick    (ref_tick_s)
  );

  m_tick_gen #(.N(SCROLL_DIV)) u_scr_tick (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (scr_en_s),
    .clr     (scr_clr_s),
    .tick    (scr_tick_s)
  );

  // Digit multiplex pointer, wraps NDIG-1 -> 0 on each refresh tick.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      dig_r <= '0;
    end else if (ref_tick_s) begin
      if (dig_r == DIG_LAST) begin
        dig_r <= '0;
      end else begin
        dig_r <= dig_r + 1'b1;
      end
    end else begin
      dig_r <= dig_r;
    end
  end

  // Scroll base: cleared on PAUSE->IDLE, stepped by dir on a scroll tick.
  // Scroll ticks only occur in RUN, so the two never coincide.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      base_r <= '0;
    end else if ((state_r == ST_PAUSE) && stop) begin
      base_r <= '0;
    end else if (scr_tick_s) begin
      if (dir) begin
        base_r <= base_r - 1'b1;
      end else begin
        base_r <= base_r + 1'b1;
      end
    end else begin
      base_r <= base_r;
    end
  end

  // Natural 4-bit wrap gives the mod-16 address.
  assign rom_adr = base_r + ADR_W'(dig_r);

  // Display registers: seg and an share one register stage so they always
  // change on the same edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      seg_r <= SEG_BLANK;
      an_r  <= '1;
    end else if (state_r != ST_IDLE) begin
      seg_r <= rom_dat;
      an_r  <= ~(AN_ONE << dig_r);
    end else begin
      seg_r <= SEG_BLANK;
      an_r  <= '1;
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign base = base_r;
  assign busy = (state_r != ST_IDLE);

endmodule
